// File: rtl/demux_pkg.sv
// Shared defaults for the 1-to-2 demultiplexer with per-lane memory.
// Lane FIFOs derive their own pointer/count widths from the DEPTH they are given.
package demux_pkg;

    localparam int DEFAULT_WIDTH = 2;
    localparam int DEFAULT_DEPTH = 4;
    localparam int PTR_W         = $clog2(DEFAULT_DEPTH);
    localparam int CNT_W         = PTR_W + 1;

    // Wide enough for any practical lane width; lanes slice the bits they need.
    localparam int                   MAX_WIDTH  = 64;
    localparam logic [MAX_WIDTH-1:0] RESET_DATA = '0;

endpackage

// File: rtl/fifo_lane.sv
// Synchronous FIFO for one demux lane. The registered output tracks the head word
// and keeps the last delivered word once the lane runs empty.
module fifo_lane
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int                LPTR_W   = $clog2(DEPTH);
    localparam int                LCNT_W   = LPTR_W + 1;
    localparam logic [LCNT_W-1:0] FULL_CNT = LCNT_W'(DEPTH);
    localparam logic [WIDTH-1:0]  DOUT_RST = RESET_DATA[WIDTH-1:0];

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [LPTR_W-1:0] r_wr_ptr;
    logic [LPTR_W-1:0] r_rd_ptr;
    logic [LCNT_W-1:0] r_count;
    logic [WIDTH-1:0]  r_dout;

    logic              w_do_pop;
    logic              w_do_push;
    logic [LCNT_W-1:0] w_cnt_after_pop;
    logic [LPTR_W-1:0] w_next_rd;
    logic [WIDTH-1:0]  w_next_head;

    // A pop on an empty lane is ignored; a push on a full lane is refused.
    assign w_do_pop        = pop & (r_count != '0);
    assign w_do_push       = push & (r_count != FULL_CNT);
    assign w_cnt_after_pop = r_count - LCNT_W'(w_do_pop);
    assign w_next_rd       = r_rd_ptr + LPTR_W'(w_do_pop);

    // Next head: an already stored word if one survives the pop, else the word
    // being written now into an otherwise empty lane, else hold the last value.
    always_comb begin
        w_next_head = r_dout;
        if (w_cnt_after_pop != '0) begin
            w_next_head = r_mem[w_next_rd];
        end else if (w_do_push) begin
            w_next_head = din;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= DOUT_RST;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + LPTR_W'(1);
            end
            r_rd_ptr <= w_next_rd;
            r_count  <= w_cnt_after_pop + LCNT_W'(w_do_push);
            r_dout   <= w_next_head;
        end
    end

    assign dout  = r_dout;
    assign valid = (r_count != '0);
    assign full  = (r_count == FULL_CNT);

endmodule

// File: rtl/demux_memoria.sv
// 1-to-2 demultiplexer with memory: each accepted word is routed by selector into
// one of two independent lane FIFOs that drain through their own handshakes.
module demux_memoria
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             selector,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] data_out0,
    output logic             valid_out0,
    input  logic             pop0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out1,
    input  logic             pop1
);

    logic w_full0;
    logic w_full1;
    logic w_push;
    logic w_push0;
    logic w_push1;

    // Handshakes: an input word transfers on a rising edge when valid_in & ready_out;
    // ready_out reflects the selected lane's fullness before any same-cycle pop, and
    // a stalled producer holds data_in/selector. Lane k transfers when valid_outk & popk.
    assign ready_out = selector ? !w_full1 : !w_full0;
    assign w_push    = valid_in & ready_out;
    assign w_push0   = w_push & !selector;
    assign w_push1   = w_push & selector;

    fifo_lane #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane0 (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (w_push0),
        .din     (data_in),
        .pop     (pop0),
        .dout    (data_out0),
        .valid   (valid_out0),
        .full    (w_full0)
    );

    fifo_lane #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane1 (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (w_push1),
        .din     (data_in),
        .pop     (pop1),
        .dout    (data_out1),
        .valid   (valid_out1),
        .full    (w_full1)
    );

endmodule

// File: tb/tb_demux_memoria.sv
// Bench for demux_memoria: directed scenarios plus random traffic, checked by a
// monitor against per-lane queues of words the model expects each lane to hold.
module tb_demux_memoria;
  localparam int W = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         selector = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         valid_in = 1'b0;
  logic         pop0 = 1'b0;
  logic         pop1 = 1'b0;
  logic         ready_out;
  logic [W-1:0] data_out0;
  logic         valid_out0;
  logic [W-1:0] data_out1;
  logic         valid_out1;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] last0 = '0;
  logic [W-1:0] last1 = '0;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  demux_memoria #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .selector   (selector),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .pop0       (pop0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .pop1       (pop1)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-low-phase, after the driver has set this cycle's inputs.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_L) begin
        chk1("ready_out", ready_out, selector ? (exp_q1.size() < D) : (exp_q0.size() < D));
        chk1("valid_out0", valid_out0, exp_q0.size() != 0);
        if (exp_q0.size() != 0) begin
          chkw("data_out0", data_out0, exp_q0[0]);
          if (pop0) last0 = exp_q0.pop_front();
        end else begin
          chkw("data_out0_hold", data_out0, last0);
        end
        chk1("valid_out1", valid_out1, exp_q1.size() != 0);
        if (exp_q1.size() != 0) begin
          chkw("data_out1", data_out1, exp_q1[0]);
          if (pop1) last1 = exp_q1.pop_front();
        end else begin
          chkw("data_out1_hold", data_out1, last1);
        end
      end
    end
  end

  // One cycle of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                      input logic p0, input logic p1, input logic rst_n,
                      output logic accepted);
    @(negedge clk);
    reset_L  = rst_n;
    valid_in = v;
    selector = s;
    data_in  = d;
    pop0     = p0;
    pop1     = p1;
    accepted = rst_n && v && (s ? (exp_q1.size() < D) : (exp_q0.size() < D));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      last0 = '0;
      last1 = '0;
    end else if (accepted) begin
      if (s) exp_q1.push_back(d);
      else exp_q0.push_back(d);
    end
  endtask

  task automatic send(input logic s, input logic [W-1:0] d, input logic p0, input logic p1);
    logic a;
    int   n;
    n = 0;
    a = 1'b0;
    while (!a && n < 40) begin
      step(1'b1, s, d, p0, p1, 1'b1, a);
      n++;
    end
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h lane %0b not accepted within 40 cycles", d, s);
    end
  endtask

  task automatic idle(input int n, input logic p0, input logic p1);
    logic a;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 3)), p0, p1, 1'b1, a);
    end
  endtask

  initial begin
    logic         a;
    logic         v;
    logic         s;
    logic [W-1:0] d;
    logic         rn;

    // Reset held two cycles while a word is offered.
    step(1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, a);
    idle(2, 1'b0, 1'b0);

    // Routing.
    send(1'b0, 2'b01, 1'b0, 1'b0);
    send(1'b1, 2'b10, 1'b0, 1'b0);
    send(1'b0, 2'b11, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(4, 1'b1, 1'b1);

    // Fill lane 0, stall the fifth word, lane 1 still accepts, then drain.
    send(1'b0, 2'd0, 1'b0, 1'b0);
    send(1'b0, 2'd1, 1'b0, 1'b0);
    send(1'b0, 2'd2, 1'b0, 1'b0);
    send(1'b0, 2'd3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, a);
    idle(1, 1'b0, 1'b0);
    send(1'b1, 2'd1, 1'b0, 1'b0);
    send(1'b0, 2'd0, 1'b1, 1'b0);
    idle(8, 1'b1, 1'b1);

    // Memory hold on lane 1.
    send(1'b1, 2'b10, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    idle(5, 1'b0, 1'b0);

    // Pushes against a full lane 0 while it drains, crossing pointer wrap.
    for (int i = 0; i < D; i++) send(1'b0, W'(i + 1), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(1'b0, W'($urandom_range(0, 3)), 1'b1, 1'b0);
    idle(8, 1'b1, 1'b0);

    // Reset mid-stream discards lane 0 contents.
    send(1'b0, 2'd3, 1'b0, 1'b0);
    send(1'b0, 2'd2, 1'b0, 1'b0);
    send(1'b0, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, a);
    idle(1, 1'b0, 1'b0);
    send(1'b0, 2'd2, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b0);

    // Random traffic; a stalled word is held until accepted.
    v = 1'b0;
    s = 1'b0;
    d = '0;
    a = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (!(v && !a)) begin
        v = ($urandom_range(0, 3) != 0);
        s = 1'($urandom_range(0, 1));
        d = W'($urandom_range(0, 3));
      end
      rn = ($urandom_range(0, 199) != 0);
      step(v, s, d, ($urandom_range(0, 2) == 0) ^ (i[8]), ($urandom_range(0, 2) != 0), rn, a);
      if (!rn) a = 1'b1;
    end
    idle(12, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
